// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: FIFO head, handshake and status pulses.
// The receiver drives through the master modport; the command parser uses slave.
interface uart_rx_fifo_if #(
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 8
);
    logic [NUM_DATA_BITS-1:0]      o_data;
    logic                          o_parity_err;
    logic                          o_frame_err;
    logic                          o_valid;
    logic                          i_ready;
    logic                          o_overrun;
    logic                          o_break;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;

    modport master (
        output o_data, o_parity_err, o_frame_err, o_valid, o_overrun, o_break, o_fifo_level,
        input  i_ready
    );

    modport slave (
        input  o_data, o_parity_err, o_frame_err, o_valid, o_overrun, o_break, o_fifo_level,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority voting, parity/framing/break detection
// and a show-ahead output FIFO so the command parser can stall without losing bytes.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int BAUD_RATE       = 3_000_000,
    parameter int OVERSAMPLE_RATE = 16,
    parameter int NUM_DATA_BITS   = 8,
    parameter int PARITY_MODE     = 2,
    parameter int NUM_STOP_BITS   = 1,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_rx,
    uart_rx_fifo_if.master rx_if
);
    localparam int TICK_HZ = BAUD_RATE * OVERSAMPLE_RATE;
    localparam int DIV     = (CLK_FREQ_HZ + TICK_HZ / 2) / TICK_HZ;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE_RATE);
    localparam int H       = OVERSAMPLE_RATE / 2;
    localparam int BIT_W   = $clog2(NUM_DATA_BITS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int WW      = NUM_DATA_BITS + 2;
    localparam logic ODD   = (PARITY_MODE == 2);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx_fifo: clock too slow for BAUD_RATE*OVERSAMPLE_RATE");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               sync_q, sync_d;
    logic                     rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [OS_W-1:0]          os_q, os_d;
    logic                     s0_q, s0_d, s1_q, s1_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic                     stop_q, stop_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                     zero_q, zero_d;
    logic                     commit_q, commit_d, brk_q, brk_d, ovr_q, ovr_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic [WW-1:0]            mem_q [FIFO_DEPTH];

    logic rx, tick, decide, bit_end, vote;
    logic valid, full, pop, push;
    logic [WW-1:0] head;

    assign rx      = sync_q[2];
    assign tick    = (div_q == DIV_W'(DIV - 1));
    assign decide  = tick && (os_q == OS_W'(H + 1));
    assign bit_end = tick && (os_q == OS_W'(OVERSAMPLE_RATE - 1));
    assign vote    = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        sync_d    = {sync_q[1:0], i_rx};
        rx_prev_d = rx;
        div_d     = div_q;
        os_d      = os_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        zero_d    = zero_q;
        commit_d  = 1'b0;
        brk_d     = 1'b0;

        if (state_q == IDLE) begin
            div_d = '0;
            os_d  = '0;
        end else if (tick) begin
            div_d = '0;
            os_d  = bit_end ? '0 : os_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (tick && os_q == OS_W'(H - 1)) s0_d = rx;
        if (tick && os_q == OS_W'(H))     s1_d = rx;

        case (state_q)
            IDLE: if (rx_prev_q && !rx) begin
                state_d   = START;
                par_err_d = 1'b0;
                frm_err_d = 1'b0;
                zero_d    = 1'b1;
            end
            START: begin
                if (decide && vote) state_d = IDLE;
                else if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[NUM_DATA_BITS-1:1]};
                    zero_d  = zero_q & ~vote;
                end
                if (bit_end) begin
                    if (bit_q == BIT_W'(NUM_DATA_BITS - 1)) begin
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_err_d = (^shift_q) ^ vote ^ ODD;
                    zero_d    = zero_q & ~vote;
                end
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (decide) begin
                    frm_err_d = frm_err_q | ~vote;
                    zero_d    = zero_q & ~vote;
                    // Leave at the last stop decision so a back-to-back start edge is seen.
                    if (stop_q == 1'(NUM_STOP_BITS - 1)) begin
                        if (zero_q && !vote) begin
                            brk_d   = 1'b1;
                            state_d = BRK_WAIT;
                        end else begin
                            commit_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end else if (bit_end) begin
                    stop_d = stop_q + 1'b1;
                end
            end
            BRK_WAIT: if (rx) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign valid = (count_q != '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = valid && rx_if.i_ready;
    assign push  = commit_q && (!full || pop);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        ovr_d    = commit_q && full && !pop;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            os_q      <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            zero_q    <= 1'b0;
            commit_q  <= 1'b0;
            brk_q     <= 1'b0;
            ovr_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            div_q     <= div_d;
            os_q      <= os_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            zero_q    <= zero_d;
            commit_q  <= commit_d;
            brk_q     <= brk_d;
            ovr_q     <= ovr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // NOTE: storage has no reset; outputs are masked by o_valid, so stale entries never show.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {frm_err_q, par_err_q, shift_q};
    end

    assign rx_if.o_data       = valid ? head[NUM_DATA_BITS-1:0] : '0;
    assign rx_if.o_parity_err = valid & head[NUM_DATA_BITS];
    assign rx_if.o_frame_err  = valid & head[NUM_DATA_BITS+1];
    assign rx_if.o_valid      = valid;
    assign rx_if.o_overrun    = ovr_q;
    assign rx_if.o_break      = brk_q;
    assign rx_if.o_fifo_level = count_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Second-generation UART receiver for the CORDIC-UART link. It adds configurable parity mode and stop-bit count, 3-sample majority voting, false-start rejection, framing and break detection, and an output FIFO with a ready/valid handshake and overrun reporting. It sits between the board RX pin and the command parser, so the parser can stall without losing bytes.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 3_000_000, line bit rate
OVERSAMPLE_RATE, 16, ticks per bit; even, 8..32
NUM_DATA_BITS, 8, data bits per frame; 5..9
PARITY_MODE, 2, 0 = none, 1 = even, 2 = odd
NUM_STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, entries; power of two, >= 2

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_rx  in  1  asynchronous serial line, idle high
o_data  out  NUM_DATA_BITS  FIFO head data, LSB = first bit received
o_parity_err  out  1  FIFO head parity-error flag
o_frame_err  out  1  FIFO head framing-error flag
o_valid  out  1  FIFO not empty
i_ready  in  1  consumer accepts head when o_valid && i_ready
o_overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full
o_break  out  1  one-cycle pulse: break condition detected
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: one clock, i_clk. Asynchronous, active-low reset on i_rst_n. All flops clear; the synchroniser presets to 1 (idle). Outputs after reset: o_data = 0, flags = 0, o_valid = 0, o_overrun = 0, o_break = 0, o_fifo_level = 0, state = IDLE. Reset mid-frame discards the partial frame and the FIFO contents.
- Synchroniser: 3-flop chain on i_rx; rx = last stage.
- Tick: DIV = round(CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE_RATE)). DIV must be >= 1; elaboration fails otherwise. The tick counter runs freely in every state except IDLE, where it is held at 0.
- Sampling: each bit counts ticks 0..OVERSAMPLE_RATE-1. The bit value is the majority of rx at ticks H-1, H and H+1, where H = OVERSAMPLE_RATE/2. The decision is made at tick H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: when rx falls (1 -> 0), go to START with the tick and oversample counters at 0.
  - START: at the decision point, a majority of 1 is a false start -> IDLE, with no output. Otherwise wait to the end of the bit, then go to DATA.
  - DATA: shift in bits LSB first. After bit NUM_DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: parity_err = (XOR of data bits XOR sampled bit) != (PARITY_MODE == 2). Ignore i_ready.
  - STOP: sample each of the NUM_STOP_BITS bits. frame_err = any stop bit sampled 0. At the decision point of the last stop bit, commit the frame, then go immediately to IDLE; do not wait for the bit end, so a back-to-back start edge is caught.
  - BRK_WAIT: remain until rx == 1, then go to IDLE.
- Break: a frame is a break when all data bits, the parity bit (if present) and every stop bit sample 0. Action: pulse o_break for 1 cycle, do not write the FIFO, go to BRK_WAIT.
- Commit: write {frame_err, parity_err, data} into the FIFO in the cycle after the last stop decision.
  - If the FIFO is full and no pop occurs in that cycle: drop the frame, pulse o_overrun for 1 cycle, leave contents unchanged.
  - If the FIFO is full and a pop occurs in the same cycle: accept the write; level is unchanged.
- FIFO: show-ahead; o_data and flags show the head whenever o_valid = 1. Pop when o_valid && i_ready. A write to an empty FIFO makes o_valid = 1 on the next cycle. Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop on an empty FIFO is not a pop; the entry is pushed.
- o_fifo_level: updated every cycle as level + push - pop.
- Latency: 1 cycle from last stop decision to FIFO write, plus 1 cycle to o_valid.
- i_ready while o_valid = 0 has no effect.

Test Plan:
- Defaults, odd parity, frame 0xA5 (parity bit 1, stop 1) -> one entry: o_data = 0xA5, parity_err = 0, frame_err = 0. o_valid rises 2 cycles after the last stop decision.
- Same frame with parity bit inverted -> o_data = 0xA5, o_parity_err = 1; 0x3C with stop bit 0 -> o_frame_err = 1.
- 0.2-bit low glitch on an idle line -> no entry, state returns to IDLE, then the next valid 0x55 is received correctly. A single-tick glitch at mid-bit inside 0x0F is masked by the majority vote.
- i_ready = 0, 9 back-to-back frames 0x00..0x08 with FIFO_DEPTH = 8 -> level 8, one o_overrun pulse. Popping then yields 0x00..0x07 in order.
- Line held low for 3 frame times -> one o_break pulse, no FIFO write, FSM in BRK_WAIT until high. The next frame 0x81 is received normally.
- PARITY_MODE = 0, NUM_STOP_BITS = 2, NUM_DATA_BITS = 7, frame 0x5A -> o_data = 0x5A. Reset asserted mid-frame -> all outputs 0 immediately, no entry from the partial frame.
